oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma.sv | 105 ++++++++++
 tb/tb_oam_dma.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared PPU definitions for the OAM DMA controller: state encoding and transfer timing constants.
package oam_dma_pkg;

   typedef logic [2:0] dma_state_t;

   localparam dma_state_t ST_IDLE  = 3'd0;
   localparam dma_state_t ST_HALT  = 3'd1;
   localparam dma_state_t ST_ALIGN = 3'd2;
   localparam dma_state_t ST_READ  = 3'd3;
   localparam dma_state_t ST_WRITE = 3'd4;

   localparam int DMA_LEN      = 256;
   localparam int DMA_CYC_EVEN = 513;
   localparam int DMA_CYC_ODD  = 514;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA ($4014): stalls the CPU and copies one 256-byte page into OAM,
// alternating a bus read with an OAM write.
//
//   state | meaning
//   IDLE  | waiting for dma_trig; dma_done pulses here after a completed transfer
//   HALT  | first stolen CPU cycle
//   ALIGN | extra cycle when the trigger landed on an odd CPU cycle
//   READ  | bus read of {page, idx}
//   WRITE | OAM write of the byte read in the previous cycle, idx advances
module oam_dma
   import oam_dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_trig,
   input  logic [7:0]  dma_page,
   input  logic [7:0]  oam_base,
   input  logic        cpu_odd,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   output logic        oam_en,
   output logic        oam_rw,
   output logic [5:0]  spr_select,
   output logic [1:0]  byte_select,
   output logic [7:0]  oam_data,
   output logic        cpu_stall,
   output logic        dma_busy,
   output logic        dma_done
);

   dma_state_t state;
   logic [7:0] idx;
   logic [7:0] page;
   logic [7:0] base;
   logic       odd;
   logic       done_q;
   logic [7:0] oam_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= 8'h00;
         page   <= 8'h00;
         base   <= 8'h00;
         odd    <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (dma_trig) begin
                  page  <= dma_page;
                  base  <= oam_base;
                  odd   <= cpu_odd;
                  idx   <= 8'h00;
                  state <= ST_HALT;
               end
            end
            ST_HALT:  state <= odd ? ST_ALIGN : ST_READ;
            ST_ALIGN: state <= ST_READ;
            ST_READ:  state <= ST_WRITE;
            ST_WRITE: begin
               idx <= idx + 8'd1;
               if (idx == 8'(DMA_LEN - 1)) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end else begin
                  state <= ST_READ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // OAM address wraps at 8 bits so a non-zero OAMADDR rotates the sprite table
   assign oam_addr = base + idx;

   always_comb begin
      mem_rd      = 1'b0;
      mem_addr    = 16'h0000;
      oam_en      = 1'b0;
      oam_rw      = 1'b1;
      oam_data    = 8'h00;
      spr_select  = 6'h00;
      byte_select = 2'h0;
      if (state == ST_READ) begin
         mem_rd   = 1'b1;
         mem_addr = {page, idx};
      end
      if (state == ST_WRITE) begin
         oam_en      = 1'b1;
         oam_rw      = 1'b0;
         oam_data    = mem_rdata;
         spr_select  = oam_addr[7:2];
         byte_select = oam_addr[1:0];
      end
   end

   assign cpu_stall = (state != ST_IDLE);
   assign dma_busy  = (state != ST_IDLE);
   assign dma_done  = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a bus memory and OAM image model, checked per cycle
// and against the expected page-to-OAM copy after each transfer.
module tb_oam_dma;

   logic        clk;
   logic        rst_n;
   logic        dma_trig;
   logic [7:0]  dma_page;
   logic [7:0]  oam_base;
   logic        cpu_odd;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        oam_en;
   logic        oam_rw;
   logic [5:0]  spr_select;
   logic [1:0]  byte_select;
   logic [7:0]  oam_data;
   logic        cpu_stall;
   logic        dma_busy;
   logic        dma_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:65535];
   logic [7:0] oam_img [0:255];
   logic       rd_v;
   logic [15:0] rd_a;

   oam_dma dut (
      .clk(clk), .rst_n(rst_n), .dma_trig(dma_trig), .dma_page(dma_page),
      .oam_base(oam_base), .cpu_odd(cpu_odd), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .oam_en(oam_en), .oam_rw(oam_rw), .spr_select(spr_select),
      .byte_select(byte_select), .oam_data(oam_data), .cpu_stall(cpu_stall),
      .dma_busy(dma_busy), .dma_done(dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus memory: a read strobed in one cycle returns its byte in the next cycle
   always @(negedge clk) begin
      rd_v = mem_rd;
      rd_a = mem_addr;
   end
   always @(posedge clk) begin
      #1;
      mem_rdata = rd_v ? mem[rd_a] : 8'($urandom);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, {cpu_stall, dma_busy, dma_done, mem_rd, mem_addr, oam_en, oam_rw,
                  oam_data, spr_select, byte_select},
            {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 6'h00, 2'h0});
   endtask

   // retrig_at / rst_at count stall cycles; 0 disables them
   task automatic run_dma(input logic [7:0] page, input logic [7:0] base, input logic odd,
                          input int retrig_at, input int rst_at);
      logic [7:0] exp_img [0:255];
      logic [7:0] last_rd;
      int stall_n, rd_n, wr_n, done_n, first_stall, first_rd, idle_after, n_exp, errs, cyc;
      stall_n = 0; rd_n = 0; wr_n = 0; done_n = 0;
      first_stall = -1; first_rd = -1; idle_after = 0; last_rd = 8'h00;
      n_exp = (rst_at == 0) ? 256 : (rst_at - 1) / 2;
      for (int i = 0; i < 256; i++) exp_img[i] = oam_img[i];
      for (int i = 0; i < n_exp; i++) exp_img[8'(base + 8'(i))] = mem[{page, 8'(i)}];

      dma_trig = 1'b1;
      dma_page = page;
      oam_base = base;
      cpu_odd  = odd;
      cyc = 0;
      while (cyc < 700 && idle_after < 4) begin
         @(negedge clk);
         cyc++;
         dma_trig = 1'b0;
         dma_page = 8'($urandom);
         oam_base = 8'($urandom);
         cpu_odd  = 1'($urandom);
         if (cpu_stall) begin
            stall_n++;
            if (first_stall < 0) first_stall = cyc;
         end else if (stall_n > 0) begin
            idle_after++;
         end
         if (dma_done) done_n++;
         check("busy_eq_stall", dma_busy, cpu_stall);
         check("rd_wr_exclusive", mem_rd & oam_en, 0);
         if (mem_rd) begin
            if (first_rd < 0) first_rd = cyc;
            check("rd_addr", mem_addr, {page, 8'(rd_n)});
            last_rd = mem[mem_addr];
            rd_n++;
         end else begin
            check("addr_idle", mem_addr, 0);
         end
         if (oam_en) begin
            check("wr_rw", oam_rw, 0);
            check("wr_addr", {spr_select, byte_select}, 8'(base + 8'(wr_n)));
            check("wr_data", oam_data, last_rd);
            oam_img[{spr_select, byte_select}] = oam_data;
            wr_n++;
         end else begin
            check("oam_idle", {oam_rw, oam_data, spr_select, byte_select}, {1'b1, 16'h0000});
         end
         if (retrig_at != 0 && stall_n == retrig_at) begin
            dma_trig = 1'b1;
            dma_page = page ^ 8'h55;
            oam_base = base ^ 8'h33;
         end
         if (rst_at != 0 && stall_n == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_outs("rst_mid_outs");
            rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               if (dma_done) done_n++;
               check("rst_stays_idle", cpu_stall, 0);
            end
            idle_after = 4;
         end
      end
      check("timeout", idle_after >= 4, 1);
      check("wr_count", wr_n, n_exp);
      check("rd_first_delay", first_rd - first_stall, (odd ? 2 : 1));
      if (rst_at == 0) begin
         check("stall_len", stall_n, (odd ? 514 : 513));
         check("done_count", done_n, 1);
      end else begin
         check("done_after_abort", done_n, 0);
      end
      errs = 0;
      for (int i = 0; i < 256; i++) if (oam_img[i] !== exp_img[i]) errs++;
      check("oam_image_errs", errs, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      dma_trig  = 1'b1;
      dma_page  = 8'h02;
      oam_base  = 8'h00;
      cpu_odd   = 1'b0;
      rd_v      = 1'b0;
      rd_a      = 16'h0000;
      mem_rdata = 8'h00;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) oam_img[i] = 8'h5A;
      for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

      // trigger held during reset must not start a transfer
      repeat (3) @(negedge clk);
      check_reset_outs("reset_outs");
      dma_trig = 1'b0;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_after_reset", cpu_stall, 0);
      end

      run_dma(8'h02, 8'h00, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) check("oam_pattern", oam_img[i * 61], 8'(i * 61) ^ 8'hA5);
      run_dma(8'h02, 8'h00, 1'b1, 0, 0);

      run_dma(8'h03, 8'hFC, 1'b0, 0, 0);
      check("wrap_first", oam_img[8'hFC], mem[16'h0300]);
      check("wrap_src4", oam_img[8'h00], mem[16'h0304]);
      check("wrap_last", oam_img[8'hFB], mem[16'h03FF]);

      run_dma(8'h41, 8'h10, 1'b0, 100, 0);

      for (int i = 0; i < 256; i++) oam_img[i] = 8'hC3;
      run_dma(8'h07, 8'h00, 1'b0, 0, 200);
      check("abort_last_new", oam_img[98], mem[16'h0762]);
      check("abort_untouched", oam_img[99], 8'hC3);

      for (int t = 0; t < 3; t++)
         run_dma(8'($urandom), 8'($urandom), 1'($urandom), 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
